sat_mac_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational saturating multiplier.
- Computes signed a*x_in with an optional fractional right-shift, optional round-half-up and optional accumulation, then saturates the result to OUT_W bits.
- Two-stage pipeline with valid/ready handshakes on both sides, so it drops into the datapath's streaming stages that feed the filter and update loops.

---
 rtl/sat_mac_pipe.sv | 136 +++++++++++++
 tb/tb_sat_mac_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sat_mac_pipe.sv
// Two-stage pipelined signed multiply / shift / round / accumulate with output saturation.
// Stage 1 registers the full-width product; stage 2 shifts, rounds, accumulates and clamps.
module sat_mac_pipe #(
   parameter int A_W   = 16,
   parameter int X_W   = 32,
   parameter int OUT_W = 32,
   parameter int FRAC  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     a,
   input  logic [X_W-1:0]     x_in,
   input  logic               acc_mode,
   input  logic               acc_clr,
   input  logic               round_en,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   x_out,
   output logic               sat,
   output logic               sat_sticky,
   input  logic               sat_clr
);

   localparam int PW  = A_W + X_W;
   localparam int W   = PW + 1;
   localparam int HSH = (FRAC > 0) ? (FRAC - 1) : 0;

   localparam logic signed [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
   localparam logic signed [W-1:0] ZERO_W = {W{1'b0}};
   localparam logic signed [W-1:0] HALF_W = (FRAC > 0) ? (ONE_W <<< HSH) : ZERO_W;
   localparam logic signed [W-1:0] MAX_W  = (ONE_W <<< (OUT_W - 1)) - ONE_W;
   localparam logic signed [W-1:0] MIN_W  = ~MAX_W;
   localparam logic [OUT_W-1:0]    MAX_O  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]    MIN_O  = {1'b1, {(OUT_W-1){1'b0}}};

   logic                    s1_valid;
   logic signed [PW-1:0]    s1_prod;
   logic                    s1_acc_mode;
   logic                    s1_acc_clr;
   logic                    s1_round;
   logic [OUT_W-1:0]        acc;

   logic                    s2_adv;
   logic                    s1_adv;
   logic                    capture;
   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    x_ext;
   logic signed [W-1:0]     prod_w;
   logic signed [W-1:0]     rnd_w;
   logic signed [W-1:0]     shift_w;
   logic signed [W-1:0]     base_w;
   logic signed [W-1:0]     sum_w;
   logic [OUT_W-1:0]        x_next;
   logic                    sat_next;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = rst_n && s1_adv;
   assign capture  = s1_valid && s2_adv;

   // Sign-extend operands so the low PW bits of the product are exact.
   assign a_ext = {{X_W{a[A_W-1]}}, a};
   assign x_ext = {{A_W{x_in[X_W-1]}}, x_in};

   // Stage-2 datapath: widen, round, shift, accumulate and clamp.
   always_comb begin
      prod_w = {s1_prod[PW-1], s1_prod};
      if (s1_round) begin
         rnd_w = HALF_W;
      end else begin
         rnd_w = ZERO_W;
      end
      shift_w = (prod_w + rnd_w) >>> FRAC;
      if (s1_acc_mode && !s1_acc_clr) begin
         base_w = {{(W-OUT_W){acc[OUT_W-1]}}, acc};
      end else begin
         base_w = ZERO_W;
      end
      sum_w = base_w + shift_w;
      if (sum_w > MAX_W) begin
         x_next   = MAX_O;
         sat_next = 1'b1;
      end else if (sum_w < MIN_W) begin
         x_next   = MIN_O;
         sat_next = 1'b1;
      end else begin
         x_next   = sum_w[OUT_W-1:0];
         sat_next = 1'b0;
      end
   end

   // Pipeline registers, accumulator and sticky saturation flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s1_prod     <= {PW{1'b0}};
         s1_acc_mode <= 1'b0;
         s1_acc_clr  <= 1'b0;
         s1_round    <= 1'b0;
         out_valid   <= 1'b0;
         x_out       <= {OUT_W{1'b0}};
         sat         <= 1'b0;
         sat_sticky  <= 1'b0;
         acc         <= {OUT_W{1'b0}};
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_prod     <= a_ext * x_ext;
               s1_acc_mode <= acc_mode;
               s1_acc_clr  <= acc_clr;
               s1_round    <= round_en;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
         end
         if (capture) begin
            x_out <= x_next;
            sat   <= sat_next;
            if (s1_acc_mode) begin
               acc <= x_next;
            end
         end
         // A new saturation outranks a simultaneous clear.
         if (capture && sat_next) begin
            sat_sticky <= 1'b1;
         end else if (sat_clr) begin
            sat_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sat_mac_pipe.sv
// Scoreboard bench for sat_mac_pipe: directed beats push expected results, monitors pop and compare.
// Two instances: integer (FRAC=0) and fractional (FRAC=15).
module tb_sat_mac_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid_d, in_valid_f, out_ready, out_ready_f;
   logic        acc_mode, acc_clr, round_en, sat_clr;
   logic [15:0] a;
   logic [31:0] x_in;
   logic        in_ready_d, in_ready_f, out_valid_d, out_valid_f;
   logic        sat_d, sat_f, sticky_d, sticky_f;
   logic [31:0] x_out_d, x_out_f;

   logic [32:0] q_d[$];
   logic [32:0] q_f[$];
   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;

   sat_mac_pipe #(.A_W(16), .X_W(32), .OUT_W(32), .FRAC(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d),
      .a(a), .x_in(x_in), .acc_mode(acc_mode), .acc_clr(acc_clr), .round_en(round_en),
      .out_valid(out_valid_d), .out_ready(out_ready), .x_out(x_out_d), .sat(sat_d),
      .sat_sticky(sticky_d), .sat_clr(sat_clr));

   sat_mac_pipe #(.A_W(16), .X_W(32), .OUT_W(32), .FRAC(15)) dut_f (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
      .a(a), .x_in(x_in), .acc_mode(acc_mode), .acc_clr(acc_clr), .round_en(round_en),
      .out_valid(out_valid_f), .out_ready(out_ready_f), .x_out(x_out_f), .sat(sat_f),
      .sat_sticky(sticky_f), .sat_clr(sat_clr));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Offer one beat, push its expected result when accepted.
   task automatic send(input bit f, input logic [15:0] av, input logic [31:0] xv,
                       input logic m, input logic c, input logic r,
                       input logic [31:0] ev, input logic es);
      bit done = 1'b0;
      a = av; x_in = xv; acc_mode = m; acc_clr = c; round_en = r;
      if (f) in_valid_f = 1'b1; else in_valid_d = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if ((f && in_ready_f) || (!f && in_ready_d)) begin
            if (f) q_f.push_back({es, ev}); else q_d.push_back({es, ev});
            n_acc++;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid_d = 1'b0;
      in_valid_f = 1'b0;
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: beat a=%h x=%h not accepted within 40 cycles", av, xv);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q_d.size() != 0 || q_f.size() != 0) && t < 50) begin
         @(posedge clk);
         t++;
      end
      if (t >= 50) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", q_d.size() + q_f.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor for the integer instance.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n && out_valid_d && out_ready) begin
         if (q_d.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL d_unexpected: actual x_out=%h, required no output", x_out_d);
         end else begin
            e = q_d.pop_front();
            chk("d_x_out", 64'(x_out_d), 64'(e[31:0]));
            chk("d_sat", 64'(sat_d), 64'(e[32]));
         end
      end
   end

   // Monitor for the fractional instance.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n && out_valid_f && out_ready_f) begin
         if (q_f.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL f_unexpected: actual x_out=%h, required no output", x_out_f);
         end else begin
            e = q_f.pop_front();
            chk("f_x_out", 64'(x_out_f), 64'(e[31:0]));
            chk("f_sat", 64'(sat_f), 64'(e[32]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid_d = 1'b0; in_valid_f = 1'b0;
      out_ready = 1'b1; out_ready_f = 1'b1;
      acc_mode = 1'b0; acc_clr = 1'b0; round_en = 1'b0; sat_clr = 1'b0;
      a = 16'h0; x_in = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready_d), 64'd0);
      chk("rst_out_valid", 64'(out_valid_d), 64'd0);
      chk("rst_x_out", 64'(x_out_d), 64'd0);
      chk("rst_sticky", 64'(sticky_d), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Integer multiply and two-cycle latency
      send(1'b0, 16'h7FFF, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h7FFF_0000, 1'b0);
      @(negedge clk);
      chk("lat_cycle1", 64'(out_valid_d), 64'd0);
      @(negedge clk);
      chk("lat_cycle2", 64'(out_valid_d), 64'd1);
      drain();

      // Saturation corners
      send(1'b0, 16'h7FFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
      send(1'b0, 16'h8000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      send(1'b0, 16'h8000, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
      drain();
      chk("sticky_set", 64'(sticky_d), 64'd1);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      chk("sticky_clr", 64'(sticky_d), 64'd0);
      send(1'b0, 16'h7FFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      @(negedge clk);
      chk("sticky_set_wins", 64'(sticky_d), 64'd1);
      drain();

      // Back-to-back accumulation and accumulator saturation
      send(1'b0, 16'd2, 32'd100, 1'b1, 1'b1, 1'b0, 32'd200, 1'b0);
      send(1'b0, 16'd3, -32'sd50, 1'b1, 1'b0, 1'b0, 32'd50, 1'b0);
      send(1'b0, 16'd1, 32'd7, 1'b1, 1'b0, 1'b0, 32'd57, 1'b0);
      send(1'b0, 16'd1, 32'h7FFF_FFF0, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFF0, 1'b0);
      send(1'b0, 16'd1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
      send(1'b0, 16'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0);
      send(1'b0, 16'd1, 32'd5, 1'b0, 1'b1, 1'b0, 32'd5, 1'b0);
      send(1'b0, 16'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0);
      drain();

      // Backpressure: only two beats fit while the output is stalled
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            send(1'b0, 16'd1, 32'd11, 1'b0, 1'b0, 1'b0, 32'd11, 1'b0);
            send(1'b0, 16'd1, 32'd22, 1'b0, 1'b0, 1'b0, 32'd22, 1'b0);
            send(1'b0, 16'd1, 32'd33, 1'b0, 1'b0, 1'b0, 32'd33, 1'b0);
            send(1'b0, 16'd1, 32'd44, 1'b0, 1'b0, 1'b0, 32'd44, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_hold_early", 64'(x_out_d), 64'd11);
            repeat (2) @(negedge clk);
            chk("bp_accepted", 64'(n_acc), 64'd2);
            chk("bp_in_ready", 64'(in_ready_d), 64'd0);
            chk("bp_out_valid", 64'(out_valid_d), 64'd1);
            chk("bp_hold_late", 64'(x_out_d), 64'd11);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      chk("bp_all_accepted", 64'(n_acc), 64'd4);
      drain();

      // Fractional shift with and without rounding
      send(1'b1, 16'h4000, 32'd3, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0);
      send(1'b1, 16'h4000, 32'd3, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0);
      send(1'b1, 16'h4000, -32'sd3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      send(1'b1, 16'h4000, -32'sd3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0);
      drain();

      // Reset with both stages occupied
      out_ready = 1'b0;
      send(1'b0, 16'd1, 32'd1000, 1'b0, 1'b0, 1'b0, 32'd1000, 1'b0);
      send(1'b0, 16'd1, 32'd2000, 1'b0, 1'b0, 1'b0, 32'd2000, 1'b0);
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready_d), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      q_d.delete();
      @(negedge clk);
      chk("rst_mid_in_ready", 64'(in_ready_d), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("rst_mid_out_valid", 64'(out_valid_d), 64'd0);
      chk("rst_mid_sticky", 64'(sticky_d), 64'd0);
      chk("rst_mid_x_out", 64'(x_out_d), 64'd0);
      send(1'b0, 16'd5, 32'd5, 1'b1, 1'b0, 1'b0, 32'd25, 1'b0);
      drain();

      chk("queues_empty", 64'(q_d.size() + q_f.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
